quad_mac_sequencer: RTL and testbench

Sequences the shared signed multiply-accumulate unit through the two Horner steps of y = (a*x + b)*x + c (mode 0), or through a streaming sum of products a*x terminated by last (mode 1). It sits between the operand source and the MAC datapath. It replaces fixed per-mode enables with a single-op-in-flight handshake toward the MAC and a valid/ready result port.

---
 rtl/quad_mac_sequencer_pkg.sv | 37 +++
 rtl/quad_mac_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_quad_mac_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_mac_sequencer_pkg.sv
// rtl/quad_mac_sequencer_pkg.sv - shared state encoding, mode constants and sign-extend helper
// Purpose: types and helpers shared by the quad_mac_sequencer slice.
//   state_t     : 3-bit FSM encoding (eight states, fully used)
//   MODE_EVAL   : mode 0, Horner evaluation y = (a*x + b)*x + c
//   MODE_STREAM : mode 1, running sum of a*x terminated by last
//   sext()      : sign-extends the low dw bits of a SEXT_W-bit value
package quad_mac_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE1    = 3'd1,
    S_WAIT1     = 3'd2,
    S_ISSUE2    = 3'd3,
    S_WAIT2     = 3'd4,
    S_ACC_ISSUE = 3'd5,
    S_ACC_WAIT  = 3'd6,
    S_OUT       = 3'd7
  } state_t;

  localparam logic MODE_EVAL   = 1'b0;
  localparam logic MODE_STREAM = 1'b1;

  // Widest accumulator the helper supports; callers cast the result to AW.
  localparam int SEXT_W = 64;

  // Copies bit dw-1 into every bit at and above dw. Works for any DW<=AW<=SEXT_W
  // so one helper serves every parameterisation of the sequencer.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v, input int dw);
    logic [SEXT_W-1:0] hi_mask;
    hi_mask = {SEXT_W{1'b1}} << dw;
    if (((v >> (dw - 1)) & 64'd1) != 64'd0) begin
      return v | hi_mask;
    end
    return v & ~hi_mask;
  endfunction

endpackage

// File: rtl/quad_mac_sequencer.sv
// rtl/quad_mac_sequencer.sv - drives a shared signed MAC through Horner evaluation or stream accumulation
// Purpose: sequences one MAC op at a time for y = (a*x + b)*x + c (mode 0) or a
//   running sum of a*x over a stream closed by in_last (mode 1).
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-low reset
//   mode                : 0 = evaluate, 1 = stream; captured with the beat
//   in_valid/in_ready   : operand beat handshake (in_ready only in IDLE)
//   in_last             : stream terminator; forwarded to done in mode 0
//   in_a/in_b/in_c/in_x : signed DW-bit operands
//   mac_en              : one-cycle issue strobe, one op outstanding at most
//   mac_op_a/op_b/addend: MAC operands, result = op_a*op_b + addend
//   mac_res_valid/res   : MAC result return, any latency >= 1
//   out_valid/ready/data: result handshake, data held until accepted
//   done                : pulse the cycle after accepting a last-flagged result
module quad_mac_sequencer
  import quad_mac_sequencer_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [DW-1:0] in_c,
  input  logic [DW-1:0] in_x,
  output logic          mac_en,
  output logic [AW-1:0] mac_op_a,
  output logic [DW-1:0] mac_op_b,
  output logic [AW-1:0] mac_addend,
  input  logic          mac_res_valid,
  input  logic [AW-1:0] mac_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic          done
);

  state_t        state;
  state_t        state_n;

  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] c_q;
  logic [DW-1:0] x_q;
  logic          last_q;
  logic          mode_q;
  logic [AW-1:0] acc;
  logic [AW-1:0] tmp;

  logic [AW-1:0] a_ext;
  logic [AW-1:0] b_ext;
  logic [AW-1:0] c_ext;

  assign a_ext = AW'(sext(SEXT_W'(a_q), DW));
  assign b_ext = AW'(sext(SEXT_W'(b_q), DW));
  assign c_ext = AW'(sext(SEXT_W'(c_q), DW));

  // Next state and MAC issue. Operand buses are zero outside the issue
  // states so an idle or freshly reset sequencer presents nothing to the MAC.
  always_comb begin
    state_n    = state;
    in_ready   = 1'b0;
    mac_en     = 1'b0;
    mac_op_a   = '0;
    mac_op_b   = '0;
    mac_addend = '0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_n = (mode == MODE_STREAM) ? S_ACC_ISSUE : S_ISSUE1;
        end
      end
      S_ISSUE1: begin
        mac_en     = 1'b1;
        mac_op_a   = a_ext;
        mac_op_b   = x_q;
        mac_addend = b_ext;
        state_n    = S_WAIT1;
      end
      S_WAIT1: begin
        if (mac_res_valid) begin
          state_n = S_ISSUE2;
        end
      end
      S_ISSUE2: begin
        mac_en     = 1'b1;
        mac_op_a   = tmp;
        mac_op_b   = x_q;
        mac_addend = c_ext;
        state_n    = S_WAIT2;
      end
      S_WAIT2: begin
        if (mac_res_valid) begin
          state_n = S_OUT;
        end
      end
      S_ACC_ISSUE: begin
        mac_en     = 1'b1;
        mac_op_a   = a_ext;
        mac_op_b   = x_q;
        mac_addend = acc;
        state_n    = S_ACC_WAIT;
      end
      S_ACC_WAIT: begin
        if (mac_res_valid) begin
          state_n = last_q ? S_OUT : S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      x_q       <= '0;
      last_q    <= 1'b0;
      mode_q    <= MODE_EVAL;
      acc       <= '0;
      tmp       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q    <= in_a;
            b_q    <= in_b;
            c_q    <= in_c;
            x_q    <= in_x;
            last_q <= in_last;
            mode_q <= mode;
          end
        end
        S_WAIT1: begin
          if (mac_res_valid) begin
            tmp <= mac_res;
          end
        end
        S_WAIT2: begin
          if (mac_res_valid) begin
            out_data  <= mac_res;
            out_valid <= 1'b1;
          end
        end
        S_ACC_WAIT: begin
          if (mac_res_valid) begin
            acc <= mac_res;
            if (last_q) begin
              out_data  <= mac_res;
              out_valid <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= last_q;
            // Evaluation results never touch acc, so an interleaved mode-0
            // op leaves a partially accumulated stream intact.
            if (mode_q == MODE_STREAM) begin
              acc <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quad_mac_sequencer.sv
// tb/tb_quad_mac_sequencer.sv - scoreboard bench for quad_mac_sequencer with a latency-programmable MAC model
module tb_quad_mac_sequencer;

  logic        clk;
  logic        reset;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [7:0]  in_c;
  logic [7:0]  in_x;
  logic        mac_en;
  logic [31:0] mac_op_a;
  logic [7:0]  mac_op_b;
  logic [31:0] mac_addend;
  logic        mac_res_valid;
  logic [31:0] mac_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        done;

  logic        in_valid16;
  logic        in_ready16;
  logic        mac16_en;
  logic [15:0] mac16_op_a;
  logic [7:0]  mac16_op_b;
  logic [15:0] mac16_addend;
  logic        mac16_res_valid;
  logic [15:0] mac16_res;
  logic        out_valid16;
  logic        out_ready16;
  logic [15:0] out_data16;
  logic        done16;

  int n_checks;
  int n_errors;
  int done_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp16_q[$];
  logic        done_due;
  logic        done_exp;

  int          mac_lat;
  int          mac_cnt;
  logic [31:0] mac_pend;

  quad_mac_sequencer #(.DW(8), .AW(32)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_x(in_x),
    .mac_en(mac_en), .mac_op_a(mac_op_a), .mac_op_b(mac_op_b), .mac_addend(mac_addend),
    .mac_res_valid(mac_res_valid), .mac_res(mac_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .done(done)
  );

  quad_mac_sequencer #(.DW(8), .AW(16)) dut16 (
    .clk(clk), .reset(reset), .mode(mode),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_last(in_last),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_x(in_x),
    .mac_en(mac16_en), .mac_op_a(mac16_op_a), .mac_op_b(mac16_op_b), .mac_addend(mac16_addend),
    .mac_res_valid(mac16_res_valid), .mac_res(mac16_res),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16), .done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC model: not reset, so an op issued before a sequencer reset still returns.
  always @(posedge clk) begin
    mac_res_valid <= 1'b0;
    if (mac_cnt > 0) begin
      mac_cnt <= mac_cnt - 1;
      if (mac_cnt == 1) begin
        mac_res_valid <= 1'b1;
        mac_res       <= mac_pend;
      end
    end
    if (mac_en) begin
      if (mac_lat <= 1) begin
        mac_res_valid <= 1'b1;
        mac_res       <= $signed(mac_op_a) * $signed(mac_op_b) + $signed(mac_addend);
      end else begin
        mac_pend <= $signed(mac_op_a) * $signed(mac_op_b) + $signed(mac_addend);
        mac_cnt  <= mac_lat - 1;
      end
    end
  end

  always @(posedge clk) begin
    mac16_res_valid <= mac16_en;
    mac16_res       <= $signed(mac16_op_a) * $signed(mac16_op_b) + $signed(mac16_addend);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop an expectation on each output handshake.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done_due) begin
      check("done_pulse", {63'd0, done}, {63'd0, done_exp});
      done_due = 1'b0;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", {32'd0, out_data}, {32'd0, e.data});
        done_due = 1'b1;
        done_exp = e.last;
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid16 && out_ready16) begin
      if (exp16_q.size() == 0) begin
        check("unexpected_out_valid16", {63'd0, out_valid16}, 64'd0);
      end else begin
        logic [15:0] e16;
        e16 = exp16_q.pop_front();
        check("out_data16", {48'd0, out_data16}, {48'd0, e16});
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic m, input int a, input int b, input int c, input int x,
                      input logic l);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_in_ready", {63'd0, in_ready}, 64'd1);
    mode     = m;
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_c     = 8'(c);
    in_x     = 8'(x);
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] en_m;
    logic [9:0] ov_m;
    logic [9:0] ir_m;
    logic       held_valid, held_data, held_ready, held_en;
    logic       stale_seen, any_valid, any_nonzero;
    int         n;
    int         d0;

    n_checks = 0; n_errors = 0; done_cnt = 0;
    done_due = 1'b0; done_exp = 1'b0;
    mac_lat = 2; mac_cnt = 0; mac_pend = '0;
    reset = 1'b0; mode = 1'b0; in_valid = 1'b0; in_valid16 = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_x = '0;
    out_ready = 1'b1; out_ready16 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_mac_en", {63'd0, mac_en}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_mac_op_a", {32'd0, mac_op_a}, 64'd0);
    check("rst_mac_op_b", {56'd0, mac_op_b}, 64'd0);
    check("rst_mac_addend", {32'd0, mac_addend}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);

    // (2*5+3)*5+4 = 69 with L=2: mac_en at 1 and 4, out_valid at 7.
    mac_lat = 2;
    push_exp(32'd69, 1'b1);
    send(1'b0, 2, 3, 4, 5, 1'b1);
    en_m = '0; ov_m = '0; ir_m = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      en_m[c] = mac_en;
      ov_m[c] = out_valid;
      ir_m[c] = in_ready;
    end
    check("t1_mac_en_cycles", {54'd0, en_m}, {54'd0, 10'b0000010010});
    check("t1_out_valid_cycles", {54'd0, ov_m}, {54'd0, 10'b0010000000});
    check("t1_in_ready_cycles", {54'd0, ir_m}, {54'd0, 10'b1100000000});
    drain("t1_drain");

    // (-1*3+0)*3+7 = -2, last=0 so no done.
    mac_lat = 3;
    push_exp(32'hFFFF_FFFE, 1'b0);
    send(1'b0, -1, 0, 7, 3, 1'b0);
    drain("t2_drain");

    // Stream 1*2 + 3*4 + 5*6 = 44, single output, one done pulse.
    mac_lat = 1;
    d0 = done_cnt;
    push_exp(32'd44, 1'b1);
    send(1'b1, 1, 0, 0, 2, 1'b0);
    send(1'b1, 3, 0, 0, 4, 1'b0);
    send(1'b1, 5, 0, 0, 6, 1'b1);
    drain("t3_drain");
    repeat (2) @(negedge clk);
    check("t3_done_count", 64'(done_cnt - d0), 64'd1);

    // Stream (2,3), eval (1,1,1,1) = 3, stream (4,5 last) = 6+20 = 26.
    mac_lat = 2;
    send(1'b1, 2, 0, 0, 3, 1'b0);
    push_exp(32'd3, 1'b0);
    send(1'b0, 1, 1, 1, 1, 1'b0);
    push_exp(32'd26, 1'b1);
    send(1'b1, 4, 0, 0, 5, 1'b1);
    drain("t6_drain");

    // Back-pressure: (1*4+2)*4+3 = 27 held while out_ready is low.
    @(posedge clk); #1 out_ready = 1'b0;
    push_exp(32'd27, 1'b0);
    send(1'b0, 1, 2, 3, 4, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_out_valid_seen", {63'd0, out_valid}, 64'd1);
    held_valid = 1'b1; held_data = 1'b1; held_ready = 1'b1; held_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      held_valid &= (out_valid == 1'b1);
      held_data  &= (out_data == 32'd27);
      held_ready &= (in_ready == 1'b0);
      held_en    &= (mac_en == 1'b0);
    end
    check("t4_valid_held", {63'd0, held_valid}, 64'd1);
    check("t4_data_held", {63'd0, held_data}, 64'd1);
    check("t4_in_ready_low", {63'd0, held_ready}, 64'd1);
    check("t4_no_mac_en", {63'd0, held_en}, 64'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    drain("t4_drain");

    // Reset during WAIT2; the stale result arrives later and must be ignored.
    mac_lat = 4;
    send(1'b0, 1, 1, 1, 1, 1'b1);
    n = 0;
    d0 = 0;
    while (d0 < 2 && n < 200) begin
      @(negedge clk);
      if (mac_en) d0++;
      n++;
    end
    check("t5_second_issue", 64'(d0), 64'd2);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    stale_seen = 1'b0; any_valid = 1'b0; any_nonzero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      stale_seen  |= mac_res_valid;
      any_valid   |= out_valid;
      any_nonzero |= mac_en | done | (mac_op_a != 32'd0) | (mac_op_b != 8'd0)
                     | (mac_addend != 32'd0) | (out_data != 32'd0) | ~in_ready;
    end
    check("t5_stale_result_arrived", {63'd0, stale_seen}, 64'd1);
    check("t5_no_out_valid", {63'd0, any_valid}, 64'd0);
    check("t5_outputs_idle", {63'd0, any_nonzero}, 64'd0);
    // (3*-4 + -2)*-4 + 5 = 61
    mac_lat = 2;
    push_exp(32'd61, 1'b0);
    send(1'b0, 3, -2, 5, -4, 1'b0);
    drain("t5_drain");

    // AW=16: (127*127)*127 = 2048383 wraps to 0x417F.
    exp16_q.push_back(16'h417F);
    n = 0;
    @(posedge clk); #1;
    while (!in_ready16 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("aw16_in_ready", {63'd0, in_ready16}, 64'd1);
    mode = 1'b0; in_a = 8'd127; in_b = 8'd0; in_c = 8'd0; in_x = 8'd127; in_last = 1'b0;
    in_valid16 = 1'b1;
    @(posedge clk); #1 in_valid16 = 1'b0;
    n = 0;
    while (exp16_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("aw16_drain", 64'(exp16_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
